// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types for the shift-register controller: command ops, FSM states and MODE encodings.
// The op encoding matches the register MODE encoding, except that READ maps to HOLD.
package shiftreg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_ROTR = 2'b01,
    OP_ROTL = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ROTR = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic [1:0] op_mode(input op_e op);
    case (op)
      OP_ROTR: op_mode = MODE_ROTR;
      OP_ROTL: op_mode = MODE_ROTL;
      OP_LOAD: op_mode = MODE_LOAD;
      default: op_mode = MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/shiftreg_rr_arb2.sv
// Two-way arbiter: round-robin, with the pointer moving to the loser on each accept.
// SHIFTREG_CTRL_FIXED_PRIO_EN: req0 always wins and the pointer is removed.
module shiftreg_rr_arb2
  import shiftreg_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

`ifdef SHIFTREG_CTRL_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = clock ^ reset ^ accept;
  assign gnt0 = req0;
  assign gnt1 = req1 & ~req0;
`else
  // ptr=0 favours req0; after a grant, favour the other side.
  logic ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= gnt0;
    end
  end

  assign gnt0 = req0 & (~req1 | ~ptr);
  assign gnt1 = req1 & (~req0 | ptr);
`endif

endmodule

// File: rtl/shiftreg_ctrl.sv
// Sequences a shared universal shift register for two requesters (LOAD/ROTR/ROTL/READ).
// Latency: READ 1, LOAD 2, ROT N N+1 cycles. Ready only in IDLE; rsp has no backpressure.
module shiftreg_ctrl
  import shiftreg_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [CNT_W-1:0] req0_count,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [CNT_W-1:0] req1_count,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_datain,
  input  logic [WIDTH-1:0] sr_dataout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             id_q;

  logic             gnt0, gnt1, idle, accept;
  op_e              acc_op;
  logic [WIDTH-1:0] acc_data;
  logic [CNT_W-1:0] acc_count;

  shiftreg_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .accept (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign idle       = (state == IDLE) & ~reset;
  assign req0_ready = idle & gnt0;
  assign req1_ready = idle & gnt1;
  assign accept     = req0_ready | req1_ready;

  assign acc_op    = op_e'(gnt1 ? req1_op : req0_op);
  assign acc_data  = gnt1 ? req1_data : req0_data;
  assign acc_count = gnt1 ? req1_count : req0_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_READ;
      data_q    <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      sr_mode   <= MODE_HOLD;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= acc_op;
            data_q <= acc_data;
            cnt_q  <= acc_count;
            id_q   <= gnt1;
            busy   <= 1'b1;
            if (acc_op == OP_LOAD || (acc_op != OP_READ && acc_count != '0)) begin
              state   <= EXEC;
              sr_mode <= op_mode(acc_op);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= gnt1;
            end
          end
        end
        EXEC: begin
          // Rotates leave EXEC on their last step, so the counter never goes below zero.
          if (op_q != OP_LOAD) begin
            cnt_q <= cnt_q - 1'b1;
          end
          if (op_q == OP_LOAD || cnt_q == CNT_W'(1)) begin
            state     <= RESP;
            sr_mode   <= MODE_HOLD;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_id    <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          sr_mode   <= MODE_HOLD;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sr_datain = '0;
    case (sr_mode)
      MODE_LOAD:            sr_datain = data_q;
      MODE_ROTR, MODE_ROTL: sr_datain = sr_dataout;
      default:              sr_datain = '0;
    endcase
  end

  assign rsp_data = rsp_valid ? sr_dataout : '0;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl with a 4-bit universal shift register model on its sr_* port.
// Expected grants follow SHIFTREG_CTRL_FIXED_PRIO_EN when it is defined.
module tb_shiftreg_ctrl;
  import shiftreg_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_op = 2'b00, req1_op = 2'b00;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic [CNT_W-1:0] req0_count = '0, req1_count = '0;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_datain, sr_dataout, rsp_data;
  logic             rsp_valid, rsp_id, busy;
  logic [WIDTH-1:0] sr_q;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  shiftreg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_count(req0_count),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_count(req1_count),
    .sr_mode(sr_mode), .sr_datain(sr_datain), .sr_dataout(sr_dataout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Universal shift register: 00 hold, 01 rotate right, 10 rotate left, 11 load DATAIN.
  always_ff @(posedge clock) begin
    if (reset) sr_q <= '0;
    else begin
      case (sr_mode)
        2'b01:   sr_q <= {sr_q[0], sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], sr_q[3]};
        2'b11:   sr_q <= sr_datain;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_dataout = sr_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rid;
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    logic [3:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic rid, input logic [1:0] op, input logic [3:0] data,
                              input logic [2:0] cnt, input logic [3:0] exp_data, input int exp_lat);
    vec_t v;
    v.rid = rid; v.op = op; v.data = data; v.cnt = cnt; v.exp_data = exp_data; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic drive_req(input logic rid, input logic vld, input logic [1:0] op,
                           input logic [3:0] data, input logic [2:0] cnt);
    if (rid) begin
      req1_valid = vld; req1_op = op; req1_data = data; req1_count = cnt;
    end else begin
      req0_valid = vld; req0_op = op; req0_data = data; req0_count = cnt;
    end
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    logic       got_rdy, got_rsp;
    logic [1:0] emode;
    int         waited, lat, mode_err;
    @(posedge clock); #1;
    drive_req(v.rid, 1'b1, v.op, v.data, v.cnt);
    got_rdy = 1'b0;
    waited = 0;
    while (!got_rdy && waited < 20) begin
      @(negedge clock);
      got_rdy = v.rid ? req1_ready : req0_ready;
      waited++;
      if (!got_rdy) @(posedge clock);
    end
    check($sformatf("v%0d_ready", idx), 32'(got_rdy), 32'd1);
    @(posedge clock); #1;
    drive_req(v.rid, 1'b0, 2'b00, 4'h0, 3'd0);
    if (!got_rdy) return;
    emode = v.op;
    got_rsp = 1'b0;
    lat = 0;
    mode_err = 0;
    while (!got_rsp && lat < 20) begin
      @(negedge clock);
      lat++;
      if (rsp_valid === 1'b1) begin
        got_rsp = 1'b1;
        check($sformatf("v%0d_rsp_id", idx), 32'(rsp_id), 32'(v.rid));
        check($sformatf("v%0d_rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
      end else if (sr_mode !== emode) begin
        mode_err++;
      end
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_exec_mode_errs", idx), 32'(mode_err), 32'd0);
    @(negedge clock);
    check($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int n, cyc, waited;
    logic g, got;
    logic exp_g;

    vecs[0]  = mk(1'b0, 2'b11, 4'b1011, 3'd0, 4'b1011, 2);
    vecs[1]  = mk(1'b1, 2'b01, 4'b0000, 3'd3, 4'b0111, 4);
    vecs[2]  = mk(1'b0, 2'b11, 4'b1011, 3'd0, 4'b1011, 2);
    vecs[3]  = mk(1'b1, 2'b10, 4'b0000, 3'd0, 4'b1011, 1);
    vecs[4]  = mk(1'b0, 2'b10, 4'b0000, 3'd1, 4'b0111, 2);
    vecs[5]  = mk(1'b1, 2'b00, 4'b0000, 3'd0, 4'b0111, 1);
    vecs[6]  = mk(1'b0, 2'b01, 4'b0000, 3'd7, 4'b1110, 8);
    vecs[7]  = mk(1'b1, 2'b11, 4'b0001, 3'd2, 4'b0001, 2);
    vecs[8]  = mk(1'b0, 2'b10, 4'b0000, 3'd2, 4'b0100, 3);
    vecs[9]  = mk(1'b1, 2'b01, 4'b0000, 3'd1, 4'b0010, 2);
    vecs[10] = mk(1'b0, 2'b00, 4'b0110, 3'd5, 4'b0010, 1);

    // Reset state, with a valid asserted to show readys stay low under reset.
    req0_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sr_mode", 32'(sr_mode), 32'd0);
    check("rst_sr_datain", 32'(sr_datain), 32'd0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_cmd(vecs[i], i);

    // Arbitration: both requesters hold READ continuously from a fresh reset.
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    drive_req(1'b0, 1'b1, 2'b00, 4'h0, 3'd0);
    drive_req(1'b1, 1'b1, 2'b00, 4'h0, 3'd0);
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (req0_ready || req1_ready) begin
        check($sformatf("arb%0d_onehot", n), 32'(req0_ready & req1_ready), 32'd0);
        g = req1_ready;
`ifdef SHIFTREG_CTRL_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = n[0];
`endif
        check($sformatf("arb%0d_grant", n), 32'(g), 32'(exp_g));
        n++;
      end
    end
    check("arb_grant_count", 32'(n), 32'd4);
    @(posedge clock); #1;
    drive_req(1'b0, 1'b0, 2'b00, 4'h0, 3'd0);
    drive_req(1'b1, 1'b0, 2'b00, 4'h0, 3'd0);
    repeat (4) @(posedge clock);

    // Reset during the 2nd EXEC cycle of ROTL 5, with req1 pending meanwhile.
    #1 drive_req(1'b0, 1'b1, 2'b10, 4'h0, 3'd5);
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge clock);
      got = req0_ready;
      waited++;
      if (!got) @(posedge clock);
    end
    check("mid_accept", 32'(got), 32'd1);
    @(posedge clock); #1;
    drive_req(1'b0, 1'b0, 2'b00, 4'h0, 3'd0);
    drive_req(1'b1, 1'b1, 2'b00, 4'h0, 3'd0);
    @(negedge clock);
    check("mid_exec1_busy", 32'(busy), 32'd1);
    check("mid_exec1_req1_ready", 32'(req1_ready), 32'd0);
    check("mid_exec1_sr_mode", 32'(sr_mode), 32'(MODE_ROTL));
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("mid_exec2_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mid_after_busy", 32'(busy), 32'd0);
    check("mid_after_sr_mode", 32'(sr_mode), 32'd0);
    check("mid_after_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_after_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clock); #1;
    drive_req(1'b1, 1'b0, 2'b00, 4'h0, 3'd0);
    @(negedge clock);
    check("mid_read_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mid_read_rsp_id", 32'(rsp_id), 32'd1);
    check("mid_read_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
